// File: rtl/sync_fifo_cnt_if.sv
// sync_fifo_cnt_if
// Purpose: groups the data path, handshake, threshold and status signals of
// sync_fifo_cnt. Clock and reset stay as plain ports on the FIFO.
// Parameters:
//   W  - data width in bits
//   AW - pointer width; count and threshold signals are AW+1 bits wide
// Signals (direction seen from the FIFO, i.e. the slave modport):
//   flush, wr_en, wr_data, rd_en, afull_th, aempty_th   inputs
//   rd_data, rd_valid, full, empty, afull, aempty,
//   count, ovf, udf                                     outputs
interface sync_fifo_cnt_if #(
  parameter int W  = 8,
  parameter int AW = 2
);
  logic          flush;
  logic          wr_en;
  logic [W-1:0]  wr_data;
  logic          rd_en;
  logic [W-1:0]  rd_data;
  logic          rd_valid;
  logic          full;
  logic          empty;
  logic [AW:0]   afull_th;
  logic [AW:0]   aempty_th;
  logic          afull;
  logic          aempty;
  logic [AW:0]   count;
  logic          ovf;
  logic          udf;

  // Producer/consumer side that drives requests and thresholds
  modport master (
    output flush, wr_en, wr_data, rd_en, afull_th, aempty_th,
    input  rd_data, rd_valid, full, empty, afull, aempty, count, ovf, udf
  );

  // FIFO side
  modport slave (
    input  flush, wr_en, wr_data, rd_en, afull_th, aempty_th,
    output rd_data, rd_valid, full, empty, afull, aempty, count, ovf, udf
  );
endinterface

// File: rtl/sync_fifo_cnt.sv
// sync_fifo_cnt
// Purpose: single-clock FIFO of any depth 2..256 with live occupancy count,
// programmable almost-full/almost-empty thresholds, flush, sticky
// overflow/underflow flags and a selectable read mode (first-word
// fall-through or registered read).
// Parameters:
//   W    - data width (1..64)
//   DP   - depth in entries (2..256, any integer)
//   FWFT - 1: rd_data shows the head entry combinationally
//          0: rd_data is loaded one cycle after an accepted read
//   AW   - pointer width, ceil(log2(DP)); count/thresholds are AW+1 bits
// Ports:
//   clk     - rising-edge clock
//   reset_n - synchronous active-low reset
//   bus     - sync_fifo_cnt_if slave modport (requests, data, status)
module sync_fifo_cnt #(
  parameter int W    = 8,
  parameter int DP   = 4,
  parameter int FWFT = 1,
  parameter int AW   = $clog2(DP)
) (
  input  logic           clk,
  input  logic           reset_n,
  sync_fifo_cnt_if.slave bus
);

  localparam logic [AW:0]   DEPTH = (AW+1)'(DP);
  localparam logic [AW-1:0] LAST  = AW'(DP-1);

  logic [W-1:0]  r_mem [DP];
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [AW:0]   r_count;
  logic          r_ovf;
  logic          r_udf;

  logic          w_full;
  logic          w_empty;
  logic          w_wrAcc;
  logic          w_rdAcc;
  logic          w_ovfEvt;
  logic          w_udfEvt;
  logic [AW-1:0] w_wrPtrNext;
  logic [AW-1:0] w_rdPtrNext;

  // Status decode straight from the registered count, so every flag moves
  // exactly one cycle after the request that changed the occupancy.
  assign w_full  = (r_count == DEPTH);
  assign w_empty = (r_count == '0);

  // Flush wins over both requests and also suppresses the error events,
  // so a flush cycle never leaves a sticky flag behind.
  assign w_wrAcc  = bus.wr_en & ~w_full  & ~bus.flush;
  assign w_rdAcc  = bus.rd_en & ~w_empty & ~bus.flush;
  assign w_ovfEvt = bus.wr_en &  w_full  & ~bus.flush;
  assign w_udfEvt = bus.rd_en &  w_empty & ~bus.flush;

  // Depth need not be a power of two, so pointers wrap at DP-1 explicitly.
  assign w_wrPtrNext = (r_wrPtr == LAST) ? '0 : r_wrPtr + 1'b1;
  assign w_rdPtrNext = (r_rdPtr == LAST) ? '0 : r_rdPtr + 1'b1;

  // Pointer, occupancy and sticky error flag register. Reset and flush
  // both return the FIFO to an empty, error-free state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else if (bus.flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      if (w_wrAcc) r_wrPtr <= w_wrPtrNext;
      if (w_rdAcc) r_rdPtr <= w_rdPtrNext;
      case ({w_wrAcc, w_rdAcc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_ovfEvt) r_ovf <= 1'b1;
      if (w_udfEvt) r_udf <= 1'b1;
    end
  end

  // Storage is not reset; only an accepted write outside reset lands here.
  always_ff @(posedge clk) begin
    if (reset_n && w_wrAcc) begin
      r_mem[r_wrPtr] <= bus.wr_data;
    end
  end

  generate
    if (FWFT != 0) begin : gFwft
      // Head entry is always presented; meaningful whenever not empty.
      assign bus.rd_data  = r_mem[r_rdPtr];
      assign bus.rd_valid = ~w_empty;
    end else begin : gRegRead
      logic [W-1:0] r_rdData;
      logic         r_rdValid;

      // Registered read: data loads on an accepted read and then holds.
      // A flush cycle has no accepted read, so rd_valid drops and the
      // last data stays on rd_data.
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          r_rdData  <= '0;
          r_rdValid <= 1'b0;
        end else begin
          r_rdValid <= w_rdAcc;
          if (w_rdAcc) r_rdData <= r_mem[r_rdPtr];
        end
      end

      assign bus.rd_data  = r_rdData;
      assign bus.rd_valid = r_rdValid;
    end
  endgenerate

  assign bus.full   = w_full;
  assign bus.empty  = w_empty;
  assign bus.count  = r_count;
  assign bus.afull  = (r_count >= bus.afull_th);
  assign bus.aempty = (r_count <= bus.aempty_th);
  assign bus.ovf    = r_ovf;
  assign bus.udf    = r_udf;

endmodule

// File: tb/tb_sync_fifo_cnt.sv
// tb_sync_fifo_cnt
// Purpose: self-checking bench for sync_fifo_cnt. Four instances cover the
// configurations exercised: A (DP=5, FWFT), B (DP=4, FWFT),
// C (DP=8, FWFT) and D (DP=4, registered read). Read data is checked
// against a scoreboard queue filled whenever a write is expected to be
// accepted.
module tb_sync_fifo_cnt;

  logic clk;
  logic reset_n;

  int nChecks;
  int nErrors;

  logic [7:0] sbQ[$];
  logic [7:0] expData;

  sync_fifo_cnt_if #(.W(8), .AW(3)) ifA ();
  sync_fifo_cnt_if #(.W(8), .AW(2)) ifB ();
  sync_fifo_cnt_if #(.W(8), .AW(3)) ifC ();
  sync_fifo_cnt_if #(.W(8), .AW(2)) ifD ();

  sync_fifo_cnt #(.W(8), .DP(5), .FWFT(1)) dutA (.clk(clk), .reset_n(reset_n), .bus(ifA.slave));
  sync_fifo_cnt #(.W(8), .DP(4), .FWFT(1)) dutB (.clk(clk), .reset_n(reset_n), .bus(ifB.slave));
  sync_fifo_cnt #(.W(8), .DP(8), .FWFT(1)) dutC (.clk(clk), .reset_n(reset_n), .bus(ifC.slave));
  sync_fifo_cnt #(.W(8), .DP(4), .FWFT(0)) dutD (.clk(clk), .reset_n(reset_n), .bus(ifD.slave));

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one edge and settle so outputs are sampled away from the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    ifA.flush = 0; ifA.wr_en = 0; ifA.rd_en = 0; ifA.wr_data = 0; ifA.afull_th = 4'd5; ifA.aempty_th = 4'd0;
    ifB.flush = 0; ifB.wr_en = 0; ifB.rd_en = 0; ifB.wr_data = 0; ifB.afull_th = 3'd4; ifB.aempty_th = 3'd0;
    ifC.flush = 0; ifC.wr_en = 0; ifC.rd_en = 0; ifC.wr_data = 0; ifC.afull_th = 4'd4; ifC.aempty_th = 4'd2;
    ifD.flush = 0; ifD.wr_en = 0; ifD.rd_en = 0; ifD.wr_data = 0; ifD.afull_th = 3'd4; ifD.aempty_th = 3'd0;
    tick();
    tick();
    reset_n = 1'b1;
    #1;
    nChecks++; if (ifA.empty !== 1'b1) begin nErrors++; $display("[TB] FAIL rst_empty: got %b expected 1", ifA.empty); end
    nChecks++; if (ifA.full !== 1'b0) begin nErrors++; $display("[TB] FAIL rst_full: got %b expected 0", ifA.full); end
    nChecks++; if (ifA.count !== 4'd0) begin nErrors++; $display("[TB] FAIL rst_count: got %0d expected 0", ifA.count); end
    nChecks++; if (ifA.rd_valid !== 1'b0) begin nErrors++; $display("[TB] FAIL rst_rdvalid: got %b expected 0", ifA.rd_valid); end
    nChecks++; if ({ifA.ovf, ifA.udf} !== 2'b00) begin nErrors++; $display("[TB] FAIL rst_flags: got %b expected 00", {ifA.ovf, ifA.udf}); end
    nChecks++; if (ifD.rd_data !== 8'h00) begin nErrors++; $display("[TB] FAIL rst_rddata_reg: got %h expected 00", ifD.rd_data); end
    nChecks++; if (ifD.rd_valid !== 1'b0) begin nErrors++; $display("[TB] FAIL rst_rdvalid_reg: got %b expected 0", ifD.rd_valid); end
  endtask

  // Fill to full, then interleave reads and writes so both pointers wrap
  task automatic test_wrap();
    sbQ.delete();
    for (int i = 0; i < 5; i++) begin
      ifA.wr_en = 1'b1; ifA.wr_data = 8'h10 + 8'(i); sbQ.push_back(ifA.wr_data);
      tick();
    end
    ifA.wr_en = 1'b0;
    nChecks++; if (ifA.full !== 1'b1) begin nErrors++; $display("[TB] FAIL wrap_full: got %b expected 1", ifA.full); end
    nChecks++; if (ifA.count !== 4'd5) begin nErrors++; $display("[TB] FAIL wrap_count: got %0d expected 5", ifA.count); end
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) begin
        expData = sbQ.pop_front();
        nChecks++; if (ifA.rd_data !== expData) begin nErrors++; $display("[TB] FAIL wrap_rd%0d: got %h expected %h", i, ifA.rd_data, expData); end
        ifA.rd_en = 1'b1;
      end else begin
        ifA.wr_en = 1'b1; ifA.wr_data = (i == 1) ? 8'h15 : 8'h16; sbQ.push_back(ifA.wr_data);
      end
      tick();
      ifA.rd_en = 1'b0; ifA.wr_en = 1'b0;
    end
    while (sbQ.size() > 0) begin
      expData = sbQ.pop_front();
      nChecks++; if (ifA.rd_data !== expData) begin nErrors++; $display("[TB] FAIL wrap_drain: got %h expected %h", ifA.rd_data, expData); end
      ifA.rd_en = 1'b1;
      tick();
    end
    ifA.rd_en = 1'b0;
    nChecks++; if (ifA.empty !== 1'b1) begin nErrors++; $display("[TB] FAIL wrap_empty: got %b expected 1", ifA.empty); end
    nChecks++; if (ifA.ovf !== 1'b0) begin nErrors++; $display("[TB] FAIL wrap_ovf: got %b expected 0", ifA.ovf); end
  endtask

  // Write into a full FIFO, then flush with requests pending
  task automatic test_overflow_flush();
    sbQ.delete();
    for (int i = 0; i < 4; i++) begin
      ifB.wr_en = 1'b1; ifB.wr_data = 8'h20 + 8'(i); sbQ.push_back(ifB.wr_data);
      tick();
    end
    ifB.wr_data = 8'hAA;
    tick();
    ifB.wr_en = 1'b0;
    nChecks++; if (ifB.ovf !== 1'b1) begin nErrors++; $display("[TB] FAIL ovf_set: got %b expected 1", ifB.ovf); end
    nChecks++; if (ifB.count !== 3'd4) begin nErrors++; $display("[TB] FAIL ovf_count: got %0d expected 4", ifB.count); end
    for (int i = 0; i < 2; i++) begin
      expData = sbQ.pop_front();
      nChecks++; if (ifB.rd_data !== expData) begin nErrors++; $display("[TB] FAIL ovf_rd%0d: got %h expected %h", i, ifB.rd_data, expData); end
      ifB.rd_en = 1'b1;
      tick();
    end
    ifB.rd_en = 1'b0;
    nChecks++; if (ifB.ovf !== 1'b1) begin nErrors++; $display("[TB] FAIL ovf_sticky: got %b expected 1", ifB.ovf); end
    // Fill back up so the dropped 0xAA would have to surface if it had been stored
    for (int i = 0; i < 2; i++) begin
      ifB.wr_en = 1'b1; ifB.wr_data = 8'h24 + 8'(i); sbQ.push_back(ifB.wr_data);
      tick();
    end
    ifB.wr_en = 1'b0;
    while (sbQ.size() > 0) begin
      expData = sbQ.pop_front();
      nChecks++; if (ifB.rd_data !== expData) begin nErrors++; $display("[TB] FAIL ovf_order: got %h expected %h", ifB.rd_data, expData); end
      ifB.rd_en = 1'b1;
      tick();
    end
    ifB.rd_en = 1'b0;
    ifB.wr_en = 1'b1; ifB.wr_data = 8'h30;
    tick();
    ifB.flush = 1'b1; ifB.rd_en = 1'b1; ifB.wr_en = 1'b1; ifB.wr_data = 8'h31;
    tick();
    ifB.flush = 1'b0; ifB.rd_en = 1'b0; ifB.wr_en = 1'b0;
    nChecks++; if (ifB.ovf !== 1'b0) begin nErrors++; $display("[TB] FAIL flush_ovf: got %b expected 0", ifB.ovf); end
    nChecks++; if (ifB.count !== 3'd0) begin nErrors++; $display("[TB] FAIL flush_count: got %0d expected 0", ifB.count); end
    nChecks++; if (ifB.empty !== 1'b1) begin nErrors++; $display("[TB] FAIL flush_empty: got %b expected 1", ifB.empty); end
    nChecks++; if (ifB.udf !== 1'b0) begin nErrors++; $display("[TB] FAIL flush_udf: got %b expected 0", ifB.udf); end
  endtask

  // Read from empty, then simultaneous read+write on empty
  task automatic test_underflow();
    sbQ.delete();
    ifA.rd_en = 1'b1;
    tick();
    ifA.rd_en = 1'b0;
    nChecks++; if (ifA.udf !== 1'b1) begin nErrors++; $display("[TB] FAIL udf_set: got %b expected 1", ifA.udf); end
    nChecks++; if (ifA.count !== 4'd0) begin nErrors++; $display("[TB] FAIL udf_count: got %0d expected 0", ifA.count); end
    ifA.flush = 1'b1;
    tick();
    ifA.flush = 1'b0;
    nChecks++; if (ifA.udf !== 1'b0) begin nErrors++; $display("[TB] FAIL udf_flush: got %b expected 0", ifA.udf); end
    ifA.rd_en = 1'b1; ifA.wr_en = 1'b1; ifA.wr_data = 8'h33; sbQ.push_back(8'h33);
    tick();
    ifA.rd_en = 1'b0; ifA.wr_en = 1'b0;
    nChecks++; if (ifA.count !== 4'd1) begin nErrors++; $display("[TB] FAIL udf_simul_count: got %0d expected 1", ifA.count); end
    nChecks++; if (ifA.udf !== 1'b1) begin nErrors++; $display("[TB] FAIL udf_simul_flag: got %b expected 1", ifA.udf); end
    expData = sbQ.pop_front();
    nChecks++; if (ifA.rd_data !== expData) begin nErrors++; $display("[TB] FAIL udf_simul_data: got %h expected %h", ifA.rd_data, expData); end
    ifA.rd_en = 1'b1;
    tick();
    ifA.rd_en = 1'b0;
    nChecks++; if (ifA.empty !== 1'b1) begin nErrors++; $display("[TB] FAIL udf_drain_empty: got %b expected 1", ifA.empty); end
  endtask

  // Threshold flags, live threshold changes and a back-to-back read+write
  task automatic test_thresholds();
    sbQ.delete();
    ifC.afull_th = 4'd4; ifC.aempty_th = 4'd2;
    for (int i = 0; i < 3; i++) begin
      ifC.wr_en = 1'b1; ifC.wr_data = 8'h40 + 8'(i); sbQ.push_back(ifC.wr_data);
      tick();
    end
    ifC.wr_en = 1'b0;
    nChecks++; if ({ifC.afull, ifC.aempty} !== 2'b00) begin nErrors++; $display("[TB] FAIL th_c3: got %b expected 00", {ifC.afull, ifC.aempty}); end
    ifC.wr_en = 1'b1; ifC.wr_data = 8'h43; sbQ.push_back(8'h43);
    tick();
    ifC.wr_en = 1'b0;
    nChecks++; if ({ifC.afull, ifC.aempty} !== 2'b10) begin nErrors++; $display("[TB] FAIL th_c4: got %b expected 10", {ifC.afull, ifC.aempty}); end
    for (int i = 0; i < 2; i++) begin
      expData = sbQ.pop_front();
      nChecks++; if (ifC.rd_data !== expData) begin nErrors++; $display("[TB] FAIL th_rd%0d: got %h expected %h", i, ifC.rd_data, expData); end
      ifC.rd_en = 1'b1;
      tick();
    end
    ifC.rd_en = 1'b0;
    nChecks++; if (ifC.count !== 4'd2) begin nErrors++; $display("[TB] FAIL th_c2_count: got %0d expected 2", ifC.count); end
    nChecks++; if ({ifC.afull, ifC.aempty} !== 2'b01) begin nErrors++; $display("[TB] FAIL th_c2: got %b expected 01", {ifC.afull, ifC.aempty}); end
    expData = sbQ.pop_front();
    nChecks++; if (ifC.rd_data !== expData) begin nErrors++; $display("[TB] FAIL b2b_data: got %h expected %h", ifC.rd_data, expData); end
    ifC.rd_en = 1'b1; ifC.wr_en = 1'b1; ifC.wr_data = 8'h44; sbQ.push_back(8'h44);
    tick();
    ifC.rd_en = 1'b0; ifC.wr_en = 1'b0;
    nChecks++; if (ifC.count !== 4'd2) begin nErrors++; $display("[TB] FAIL b2b_count: got %0d expected 2", ifC.count); end
    ifC.afull_th = 4'd2; #1;
    nChecks++; if (ifC.afull !== 1'b1) begin nErrors++; $display("[TB] FAIL th_live2: got %b expected 1", ifC.afull); end
    ifC.afull_th = 4'd0; #1;
    nChecks++; if (ifC.afull !== 1'b1) begin nErrors++; $display("[TB] FAIL th_zero: got %b expected 1", ifC.afull); end
    ifC.afull_th = 4'd9; #1;
    nChecks++; if (ifC.afull !== 1'b0) begin nErrors++; $display("[TB] FAIL th_above: got %b expected 0", ifC.afull); end
    for (int i = 0; i < 6; i++) begin
      ifC.wr_en = 1'b1; ifC.wr_data = 8'h45 + 8'(i); sbQ.push_back(ifC.wr_data);
      tick();
    end
    ifC.wr_en = 1'b0;
    nChecks++; if ({ifC.full, ifC.afull} !== 2'b10) begin nErrors++; $display("[TB] FAIL th_full_above: got %b expected 10", {ifC.full, ifC.afull}); end
    ifC.aempty_th = 4'd8; #1;
    nChecks++; if (ifC.aempty !== 1'b1) begin nErrors++; $display("[TB] FAIL th_aempty_dp: got %b expected 1", ifC.aempty); end
    ifC.aempty_th = 4'd7; #1;
    nChecks++; if (ifC.aempty !== 1'b0) begin nErrors++; $display("[TB] FAIL th_aempty_7: got %b expected 0", ifC.aempty); end
    while (sbQ.size() > 0) begin
      expData = sbQ.pop_front();
      nChecks++; if (ifC.rd_data !== expData) begin nErrors++; $display("[TB] FAIL th_drain: got %h expected %h", ifC.rd_data, expData); end
      ifC.rd_en = 1'b1;
      tick();
    end
    ifC.rd_en = 1'b0;
  endtask

  // Registered read mode: one-cycle latency, hold on underflow and flush
  task automatic test_registered_read();
    sbQ.delete();
    for (int i = 0; i < 2; i++) begin
      ifD.wr_en = 1'b1; ifD.wr_data = 8'h01 + 8'(i); sbQ.push_back(ifD.wr_data);
      tick();
    end
    ifD.wr_en = 1'b0;
    nChecks++; if (ifD.rd_valid !== 1'b0) begin nErrors++; $display("[TB] FAIL reg_idle_valid: got %b expected 0", ifD.rd_valid); end
    for (int i = 0; i < 2; i++) begin
      ifD.rd_en = 1'b1;
      tick();
      expData = sbQ.pop_front();
      nChecks++; if (ifD.rd_valid !== 1'b1) begin nErrors++; $display("[TB] FAIL reg_valid%0d: got %b expected 1", i, ifD.rd_valid); end
      nChecks++; if (ifD.rd_data !== expData) begin nErrors++; $display("[TB] FAIL reg_data%0d: got %h expected %h", i, ifD.rd_data, expData); end
    end
    tick();
    ifD.rd_en = 1'b0;
    nChecks++; if (ifD.udf !== 1'b1) begin nErrors++; $display("[TB] FAIL reg_udf: got %b expected 1", ifD.udf); end
    nChecks++; if (ifD.rd_valid !== 1'b0) begin nErrors++; $display("[TB] FAIL reg_udf_valid: got %b expected 0", ifD.rd_valid); end
    nChecks++; if (ifD.rd_data !== 8'h02) begin nErrors++; $display("[TB] FAIL reg_udf_hold: got %h expected 02", ifD.rd_data); end
    ifD.wr_en = 1'b1; ifD.wr_data = 8'h07;
    tick();
    ifD.wr_en = 1'b0; ifD.flush = 1'b1; ifD.rd_en = 1'b1;
    tick();
    ifD.flush = 1'b0; ifD.rd_en = 1'b0;
    nChecks++; if ({ifD.rd_valid, ifD.udf, ifD.empty} !== 3'b001) begin nErrors++; $display("[TB] FAIL reg_flush_flags: got %b expected 001", {ifD.rd_valid, ifD.udf, ifD.empty}); end
    nChecks++; if (ifD.rd_data !== 8'h02) begin nErrors++; $display("[TB] FAIL reg_flush_hold: got %h expected 02", ifD.rd_data); end
  endtask

  // Reset while holding data with a pending write and a sticky flag set
  task automatic test_midreset();
    sbQ.delete();
    ifA.rd_en = 1'b1;
    tick();
    ifA.rd_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ifA.wr_en = 1'b1; ifA.wr_data = 8'h60 + 8'(i);
      tick();
    end
    ifA.wr_data = 8'h63; reset_n = 1'b0;
    tick();
    reset_n = 1'b1; ifA.wr_en = 1'b0;
    nChecks++; if (ifA.count !== 4'd0) begin nErrors++; $display("[TB] FAIL mrst_count: got %0d expected 0", ifA.count); end
    nChecks++; if (ifA.empty !== 1'b1) begin nErrors++; $display("[TB] FAIL mrst_empty: got %b expected 1", ifA.empty); end
    nChecks++; if ({ifA.ovf, ifA.udf} !== 2'b00) begin nErrors++; $display("[TB] FAIL mrst_flags: got %b expected 00", {ifA.ovf, ifA.udf}); end
    for (int i = 0; i < 2; i++) begin
      ifA.wr_en = 1'b1; ifA.wr_data = 8'h70 + 8'(i); sbQ.push_back(ifA.wr_data);
      tick();
    end
    ifA.wr_en = 1'b0;
    nChecks++; if (ifA.count !== 4'd2) begin nErrors++; $display("[TB] FAIL mrst_refill: got %0d expected 2", ifA.count); end
    while (sbQ.size() > 0) begin
      expData = sbQ.pop_front();
      nChecks++; if (ifA.rd_data !== expData) begin nErrors++; $display("[TB] FAIL mrst_data: got %h expected %h", ifA.rd_data, expData); end
      ifA.rd_en = 1'b1;
      tick();
    end
    ifA.rd_en = 1'b0;
  endtask

  initial begin
    nChecks = 0;
    nErrors = 0;
    reset_n = 1'b0;
    test_reset();
    test_wrap();
    test_overflow_flush();
    test_underflow();
    test_thresholds();
    test_registered_read();
    test_midreset();
    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
